// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fronted by a small byte FIFO.
// Producers push bytes with a one-cycle strobe. Queued frames go out
// back to back with no idle cycle between them. The line idles high.
module uart_transmitter #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int FIFO_AW  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       busy,
   output logic       overflow
);

   // Clock cycles per bit, truncated. Counter is at least one bit wide.
   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;

   localparam logic [CW-1:0]      CNT_LAST = CW'(DIV - 1);
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

   // Line FSM encoding.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // FIFO storage and bookkeeping.
   logic [7:0]         r_mem [0:DEPTH-1];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_overflow;

   // Serialiser state.
   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_bit_end;
   logic [7:0]         w_head;

   assign w_full    = (r_count == CNT_FULL);
   assign w_empty   = (r_count == '0);
   assign w_bit_end = (r_cnt == CNT_LAST);
   assign w_head    = r_mem[r_rd_ptr];

   // A write while full is dropped even if the FSM pops in the same cycle.
   assign w_push = tx_wr & ~w_full;

   // The FSM takes the head byte either from IDLE or at the end of a stop
   // bit. The stop-bit pop keeps consecutive frames gap-free.
   assign w_pop = ~w_empty &
                  ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

   // FIFO data array; contents need no reset because the count gates reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers, occupancy count and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (tx_wr & w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Frame sequencer: start bit, eight data bits LSB first, stop bit.
   // Each bit lasts DIV cycles. The baud counter restarts at every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx  <= 1'b1;
               r_cnt <= '0;
               if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     // The next bit to drive is the one shifting into bit 0.
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign tx_full  = w_full;
   assign tx_empty = w_empty;
   assign busy     = (r_state != S_IDLE) | ~w_empty;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of the UART transmitter at DIV=10.
module tb_uart_transmitter;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx;
   logic       tx_full;
   logic       tx_empty;
   logic       busy;
   logic       overflow;

   int tests;
   int fails;

   uart_transmitter #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000),
      .FIFO_AW (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tx      (tx),
      .tx_full (tx_full),
      .tx_empty(tx_empty),
      .busy    (busy),
      .overflow(overflow)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Async reset at start and again mid-frame, plus tx_data ignored without tx_wr
   task automatic test_reset;
      rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00;
      #3;
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b exp 1", tx); end
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b exp 1", tx_empty); end
      tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b exp 0", tx_full); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b exp 0", overflow); end
      tick; rst = 1'b0;
      tick;
      tx_wr = 1'b1; tx_data = 8'h81;
      tick; tx_wr = 1'b0;
      tick; tick;
      tests++; if (tx !== 1'b0) begin fails++; $display("FAIL pre_rst_start: got %b exp 0", tx); end
      #2 rst = 1'b1;
      #1;
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_rst_tx: got %b exp 1", tx); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL mid_rst_empty: got %b exp 1", tx_empty); end
      #1 rst = 1'b0;
      tick;
      tx_data = 8'hFF; tx_wr = 1'b0;
      tick; tick; tick;
      tests++; if ({tx_empty, busy, tx} !== 3'b101) begin
         fails++; $display("FAIL data_no_wr: got %b exp 101", {tx_empty, busy, tx});
      end
   endtask

   // Single 0xA5 frame, checked cycle by cycle
   task automatic test_single;
      logic [9:0] fr;
      int errs;
      fr = {1'b1, 8'hA5, 1'b0};
      errs = 0;
      tx_wr = 1'b1; tx_data = 8'hA5;
      tick; tx_wr = 1'b0;
      tests++; if ({tx_empty, tx, busy} !== 3'b011) begin
         fails++; $display("FAIL single_after_wr: got %b exp 011", {tx_empty, tx, busy});
      end
      for (int k = 0; k < 100; k++) begin
         tick;
         if (k == 0) begin
            tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL single_empty_n1: got %b exp 1", tx_empty); end
         end
         if (tx !== fr[k/10] || busy !== 1'b1) errs++;
      end
      tests++; if (errs != 0) begin fails++; $display("FAIL single_wave: got %0d bad cycles exp 0", errs); end
      tick;
      tests++; if ({busy, tx, tx_empty} !== 3'b011) begin
         fails++; $display("FAIL single_end: got %b exp 011", {busy, tx, tx_empty});
      end
   endtask

   // 9-byte burst filling the FIFO, then a write while full
   task automatic test_burst_overflow;
      logic [7:0] got [9];
      int errs;
      int t;
      int f;
      int r;
      for (int i = 0; i < 9; i++) got[i] = 8'h00;
      errs = 0;
      for (int i = 0; i < 9; i++) begin
         tx_wr = 1'b1; tx_data = 8'(i);
         tick;
      end
      tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL burst_full: got %b exp 1", tx_full); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL burst_ovf0: got %b exp 0", overflow); end
      tx_data = 8'hFF;
      tick; tx_wr = 1'b0;
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", overflow); end
      tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL ovf_count: got full=%b exp 1", tx_full); end
      // t counts cycles since the first frame's start bit appeared
      t = 8;
      while (t < 1050) begin
         tick; t++;
         if (t < 900) begin
            f = t / 100; r = t % 100;
            if (r == 0 && tx !== 1'b0) errs++;
            if (r == 99 && tx !== 1'b1) errs++;
            if (r % 10 == 5) begin
               if (r / 10 == 0 && tx !== 1'b0) errs++;
               else if (r / 10 == 9 && tx !== 1'b1) errs++;
               else if (r / 10 >= 1 && r / 10 <= 8) got[f][r/10-1] = tx;
            end
         end else begin
            if (tx !== 1'b1) errs++;
         end
         if (t == 900) begin
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL burst_busy_end: got %b exp 0", busy); end
         end
      end
      tests++; if (errs != 0) begin fails++; $display("FAIL burst_framing: got %0d bad samples exp 0", errs); end
      for (int i = 0; i < 9; i++) begin
         tests++; if (got[i] !== 8'(i)) begin fails++; $display("FAIL burst_byte%0d: got %h exp %h", i, got[i], 8'(i)); end
      end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL burst_drained: got %b exp 1", tx_empty); end
   endtask

   // Reset during data bit 3 of 0x3C with two bytes queued behind it
   task automatic test_reset_mid_frame;
      int errs;
      errs = 0;
      tx_wr = 1'b1; tx_data = 8'h3C; tick;
      tx_data = 8'h11; tick;
      tx_data = 8'h22; tick;
      tx_wr = 1'b0;
      for (int i = 0; i < 44; i++) tick;
      tests++; if ({tx, tx_empty, busy} !== 3'b101) begin
         fails++; $display("FAIL pre_rst_bit3: got %b exp 101", {tx, tx_empty, busy});
      end
      #2 rst = 1'b1;
      #1;
      tests++; if ({tx, tx_empty, busy, overflow} !== 4'b1100) begin
         fails++; $display("FAIL rst_bit3: got %b exp 1100", {tx, tx_empty, busy, overflow});
      end
      #2 rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (tx !== 1'b1) errs++;
      end
      tests++; if (errs != 0) begin fails++; $display("FAIL rst_quiet: got %0d low cycles exp 0", errs); end
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL rst_discard: got %b exp 1", tx_empty); end
   endtask

   // Push on the stop-to-idle edge: one idle cycle, then 0x55
   task automatic test_back_to_back;
      logic [7:0] b;
      int errs;
      errs = 0;
      b = 8'h00;
      tx_wr = 1'b1; tx_data = 8'hA0; tick; tx_wr = 1'b0;
      tick;
      for (int i = 0; i < 99; i++) tick;
      tx_wr = 1'b1; tx_data = 8'h55;
      tick; tx_wr = 1'b0;
      tests++; if ({tx, busy, tx_empty} !== 3'b110) begin
         fails++; $display("FAIL gap_idle: got %b exp 110", {tx, busy, tx_empty});
      end
      tick;
      tests++; if (tx !== 1'b0) begin fails++; $display("FAIL gap_start: got %b exp 0", tx); end
      for (int k = 1; k < 100; k++) begin
         tick;
         if (k % 10 == 5) begin
            if (k / 10 == 0 && tx !== 1'b0) errs++;
            else if (k / 10 == 9 && tx !== 1'b1) errs++;
            else if (k / 10 >= 1 && k / 10 <= 8) b[k/10-1] = tx;
         end
      end
      tests++; if (errs != 0) begin fails++; $display("FAIL gap_framing: got %0d bad exp 0", errs); end
      tests++; if (b !== 8'h55) begin fails++; $display("FAIL gap_byte: got %h exp 55", b); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset;
      test_single;
      test_burst_overflow;
      test_reset_mid_frame;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
